// File: rtl/btn_pkg.sv
// Shared types and limits for the push-button debouncer.
package btn_pkg;

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        RISE = 2'd1,
        HIGH = 2'd2,
        FALL = 2'd3
    } db_state_e;

    localparam int DEBOUNCE_MIN = 1;
    localparam int DEBOUNCE_MAX = 65535;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, async active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Nothing may sit between the two flops; the first is allowed to go metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Synchronises and debounces a raw push-button; emits one-cycle press/release pulses.
module button_debouncer
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_raw,
    output logic button_pulse,
    output logic button_level,
    output logic release_pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic            DIRECT   = (DEBOUNCE_CYCLES == 1);

    if (DEBOUNCE_CYCLES < DEBOUNCE_MIN || DEBOUNCE_CYCLES > DEBOUNCE_MAX) begin : g_bad_param
        $error("button_debouncer: DEBOUNCE_CYCLES out of range");
    end

    logic             raw_sync;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;
    logic             rel_q, rel_d;

    sync_2ff u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (button_raw),
        .sync_o  (raw_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOW;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            LOW: begin
                if (raw_sync) begin
                    // With a one-sample window the first differing sample is already conclusive.
                    state_d = DIRECT ? HIGH : RISE;
                    cnt_d   = DIRECT ? '0 : CNT_W'(1);
                end
            end
            RISE: begin
                if (!raw_sync) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!raw_sync) begin
                    state_d = DIRECT ? LOW : FALL;
                    cnt_d   = DIRECT ? '0 : CNT_W'(1);
                end
            end
            FALL: begin
                if (raw_sync) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the transition so they land with the new level.
    always_comb begin
        level_d = (state_d == HIGH) || (state_d == FALL);
        pulse_d = (state_d == HIGH) && ((state_q == LOW) || (state_q == RISE));
        rel_d   = (state_d == LOW) && ((state_q == HIGH) || (state_q == FALL));
    end

    assign button_pulse  = pulse_q;
    assign button_level  = level_q;
    assign release_pulse = rel_q;

endmodule
